// File: rtl/kgprisc_pkg.sv
// Shared types for the KGPRISC boot loader: FSM state encoding, instruction word, header size.
// ST_CHK exists only when LOADER_CHECKSUM_EN is defined.
package kgprisc_pkg;

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHK  = 3'd3,
`endif
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_e;

  typedef logic [31:0] instr_word_t;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: boot byte stream -> instruction memory words; LOADER_CHECKSUM_EN adds an XOR trailer byte.
// Latency: mem_we one cycle after the 4th byte of a word; done/err/cpu_rst_n lag the state by one cycle.
// Backpressure: in_ready is combinational from state, low only in DONE/ERR until load_req re-arms.
module imem_loader
  import kgprisc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e ST_END = ST_CHK;
`else
  localparam loader_state_e ST_END = ST_DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  instr_word_t       shift_q, shift_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  instr_word_t       mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_n_q, done_q, err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic        accept;
  logic [15:0] hdr_n;
  logic        last_word;

  assign hdr_n     = {hdr_hi_q, in_data};
  assign last_word = (17'(word_idx_q) + 17'd1) == {1'b0, n_q};
  assign accept    = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_HDR0, ST_HDR1, ST_DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:                    in_ready = 1'b1;
`endif
      default:                   in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hdr_hi_d    = hdr_hi_q;
    n_d         = n_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    case (state_q)
      ST_HDR0: begin
        if (accept) begin
          hdr_hi_d = in_data;
          state_d  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (accept) begin
          n_d        = hdr_n;
          word_idx_d = '0;
          byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = 8'h00;
`endif
          if ({16'd0, hdr_n} > 32'(MAX_WORDS)) state_d = ST_ERR;
          else if (hdr_n == 16'd0)             state_d = ST_END;
          else                                 state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          shift_d    = {shift_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_idx_q;
            mem_wdata_d = {shift_q[23:0], in_data};
            // Index stops at N-1; N <= MAX_WORDS keeps it inside the address range.
            if (last_word) state_d = ST_END;
            else           word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE, ST_ERR: begin
        if (load_req) begin
          state_d    = ST_HDR0;
          hdr_hi_d   = 8'h00;
          n_d        = 16'd0;
          word_idx_d = '0;
          byte_cnt_d = 2'd0;
          shift_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = 8'h00;
`endif
        end
      end
      default: state_d = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HDR0;
      hdr_hi_q    <= 8'h00;
      n_q         <= 16'd0;
      word_idx_q  <= '0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      hdr_hi_q    <= hdr_hi_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= (state_q == ST_DONE);
      done_q      <= (state_q == ST_DONE);
      err_q       <= (state_q == ST_ERR);
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of whole boot streams plus hand-written corner sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        load_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .load_req(load_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  typedef struct {
    string       name;
    int          nb;
    logic [95:0] bytes;
    bit          tog;
    int          nw;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Call at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high byte=0x%0h", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    load_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic run_vec(input vec_t v);
    do_reset();
    for (int i = 0; i < v.nb; i++) begin
      send_byte(v.bytes[95-8*i -: 8]);
      if (v.tog) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk({v.name, "_nwrites"}, wr_addr.size(), v.nw);
    if (v.nw >= 1 && wr_addr.size() >= 1) begin
      chk({v.name, "_addr0"}, {22'd0, wr_addr[0]}, 32'd0);
      chk({v.name, "_data0"}, wr_data[0], v.d0);
    end
    if (v.nw >= 2 && wr_addr.size() >= 2) begin
      chk({v.name, "_addr1"}, {22'd0, wr_addr[1]}, 32'd1);
      chk({v.name, "_data1"}, wr_data[1], v.d1);
    end
    chk({v.name, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
    chk({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({v.name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, v.exp_done});
    chk({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] wb[4];
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    load_req = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    vecs.push_back('{"two_words", 11, 96'h0002_1234_5678_9ABC_DEF0_0000, 1'b0, 2, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0});
    vecs.push_back('{"zero_words", 3, 96'h0000_0000_0000_0000_0000_0000, 1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"zero_bad_ck", 3, 96'h0000_0100_0000_0000_0000_0000, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"too_many", 2, 96'h0401_0000_0000_0000_0000_0000, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"toggle_valid", 7, 96'h0001_AABB_CCDD_0000_0000_0000, 1'b1, 1, 32'hAABBCCDD, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"ck_good", 7, 96'h0001_0102_0304_0400_0000_0000, 1'b0, 1, 32'h01020304, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"ck_bad", 7, 96'h0001_0102_0304_0500_0000_0000, 1'b0, 1, 32'h01020304, 32'h0, 1'b0, 1'b1});
`else
    vecs.push_back('{"two_words", 10, 96'h0002_1234_5678_9ABC_DEF0_0000, 1'b0, 2, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0});
    vecs.push_back('{"zero_words", 2, 96'h0000_0000_0000_0000_0000_0000, 1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"too_many", 2, 96'h0401_0000_0000_0000_0000_0000, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"toggle_valid", 6, 96'h0001_AABB_CCDD_0000_0000_0000, 1'b1, 1, 32'hAABBCCDD, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"one_word", 6, 96'h0001_CAFE_F00D_0000_0000_0000, 1'b0, 1, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0});
`endif

    foreach (vecs[k]) run_vec(vecs[k]);

    // Asynchronous reset from DONE with non-zero write outputs, away from any clock edge.
    run_vec(vecs[0]);
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("arst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // done lags the DONE state by one cycle after the final header (or checksum) byte.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("lag_done_early", {31'd0, done}, 32'd0);
    chk("lag_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("lag_done", {31'd0, done}, 32'd1);
    chk("lag_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("lag_nwrites", wr_addr.size(), 32'd0);

    // Re-arm from DONE with a byte offered in the same cycle; that byte must not be taken.
    in_data  = 8'h05;
    in_valid = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    in_valid = 1'b0;
    chk("rearm_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rearm_cpu_rst_n_lag", {31'd0, cpu_rst_n}, 32'd1);
    @(negedge clk);
    chk("rearm_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("rearm_done", {31'd0, done}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    repeat (3) @(negedge clk);
    chk("rearm_nwrites", wr_addr.size(), 32'd1);
    if (wr_data.size() >= 1) chk("rearm_data", wr_data[0], 32'hDEADBEEF);
    chk("rearm_done_again", {31'd0, done}, 32'd1);

    // Reset mid-word discards the partial word.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    repeat (3) @(negedge clk);
    chk("midrst_nwrites", wr_addr.size(), 32'd1);
    if (wr_data.size() >= 1) begin
      chk("midrst_addr", {22'd0, wr_addr[0]}, 32'd0);
      chk("midrst_data", wr_data[0], 32'h11223344);
    end
    chk("midrst_done", {31'd0, done}, 32'd1);

    // load_req outside DONE/ERR is ignored.
    do_reset();
    send_byte(8'h00);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hCC);
`endif
    repeat (3) @(negedge clk);
    chk("ignreq_nwrites", wr_addr.size(), 32'd1);
    if (wr_data.size() >= 1) chk("ignreq_data", wr_data[0], 32'h55667788);
    chk("ignreq_done", {31'd0, done}, 32'd1);

    // N = MAX_WORDS = 1024 is accepted and fills the whole memory.
    do_reset();
    send_byte(8'h04);
    send_byte(8'h00);
    @(negedge clk);
    chk("max_err", {31'd0, err}, 32'd0);
    chk("max_in_ready", {31'd0, in_ready}, 32'd1);
    x = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      wb[0] = i[7:0];
      wb[1] = {6'd0, i[9:8]};
      wb[2] = 8'hA5;
      wb[3] = 8'h5A;
      for (int j = 0; j < 4; j++) begin
        send_byte(wb[j]);
        x = x ^ wb[j];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x);
`endif
    repeat (3) @(negedge clk);
    chk("max_nwrites", wr_addr.size(), 32'd1024);
    if (wr_addr.size() == 1024) begin
      chk("max_first_addr", {22'd0, wr_addr[0]}, 32'd0);
      chk("max_first_data", wr_data[0], 32'h0000A55A);
      chk("max_last_addr", {22'd0, wr_addr[1023]}, 32'd1023);
      chk("max_last_data", wr_data[1023], 32'hFF03A55A);
    end
    chk("max_done", {31'd0, done}, 32'd1);
    chk("max_err_end", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, sets the instruction-memory word-address width; depth is 2^ADDR_W words.
REQ-002 Parameter MAX_WORDS, default 2^ADDR_W, is the largest accepted word count.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-low reset.
REQ-005 Port in_data  input  8  is the boot-stream byte.
REQ-006 Port in_valid  input  1  means in_data is valid.
REQ-007 Port in_ready  output  1  means the loader accepts a byte this cycle.
REQ-008 Port load_req  input  1  is a one-cycle pulse that re-arms the loader from DONE or ERR.
REQ-009 Port mem_we  output  1  is the instruction-memory write strobe.
REQ-010 Port mem_addr  output  ADDR_W  is the word write address.
REQ-011 Port mem_wdata  output  32  is the write word.
REQ-012 Port cpu_rst_n  output  1  holds KGPRISC in reset while low.
REQ-013 Port done  output  1  means the load completed successfully.
REQ-014 Port err  output  1  means the load was aborted.

Function
REQ-015 A byte SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-016 Stream format: 2 header bytes giving count N (16-bit, MSB first), then N words of 4 bytes each, MSB first.
REQ-017 States SHALL be HDR0, HDR1, DATA, CHK (macro only), DONE and ERR.
REQ-018 in_ready SHALL be 1 in HDR0, HDR1, DATA and CHK, and 0 in DONE and ERR.
REQ-019 HDR0 -> HDR1 on acceptance.
REQ-020 On acceptance in HDR1: if N > MAX_WORDS, go to ERR; if N = 0, go to DONE with no write; otherwise go to DATA with the word counter at 0.
REQ-021 In DATA, a 2-bit byte counter SHALL shift bytes into a 32-bit assembly register.
REQ-022 On acceptance of the 4th byte, mem_we SHALL pulse for exactly the next cycle, with mem_addr = word index and mem_wdata = the assembled word.
REQ-023 After the write of word N-1, the next state SHALL be DONE (or CHK when the macro is defined).
REQ-024 The word index SHALL count 0..N-1 with no wrap; N <= MAX_WORDS guarantees this.
REQ-025 mem_we SHALL never assert outside the cycle after a 4th-byte acceptance.
REQ-026 done, err and cpu_rst_n SHALL be registered and lag the state by one cycle.
REQ-027 cpu_rst_n = 1 only while in DONE; done = (state==DONE); err = (state==ERR).
REQ-028 load_req in DONE or ERR SHALL go to HDR0 and clear all counters; cpu_rst_n SHALL drop the following cycle.
REQ-029 load_req in any other state SHALL be ignored.
REQ-030 A byte in flight while load_req is sampled SHALL NOT be accepted.

Reset
REQ-031 Asserting rst SHALL immediately, without waiting for a clock edge, set state=HDR0, all counters to 0, and outputs in_ready=1 (combinational from state), mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, done=0, err=0.
REQ-032 Reset mid-word SHALL discard the partial word and perform no write.

Configuration
REQ-033 When LOADER_CHECKSUM_EN is defined: after the last data byte, state CHK SHALL accept one byte; if it equals the XOR of all data bytes, go to DONE, otherwise go to ERR.
REQ-034 When LOADER_CHECKSUM_EN is defined and N=0, the expected checksum SHALL be 0x00 and HDR1 SHALL go to CHK.
REQ-035 Without LOADER_CHECKSUM_EN: state CHK and the XOR register SHALL NOT exist, and the last write SHALL lead directly to DONE.

Structure
REQ-036 Package kgprisc_pkg SHALL hold the loader state enum, a 32-bit instruction word typedef and the header byte-count constant (2).
REQ-037 No sub-module; a single FSM with its counters.

Verification
REQ-038 Stream 00 02 | 12 34 56 78 | 9A BC DE F0 -> writes addr0=0x12345678, addr1=0x9ABCDEF0; done=1; cpu_rst_n=1.
REQ-039 Stream 00 00 -> no mem_we; done=1 two cycles after the second header byte.
REQ-040 Header 04 01 with ADDR_W=10 (N=1025) -> err=1; in_ready=0; no writes.
REQ-041 in_valid toggled 1/0 on alternate cycles during 00 01 AA BB CC DD -> single write 0xAABBCCDD at addr 0.
REQ-042 rst pulsed low after 2 data bytes, then stream 00 01 11 22 33 44 -> only write 0x11223344 at addr 0.
REQ-043 With LOADER_CHECKSUM_EN: 00 01 01 02 03 04 then 04 -> done=1; the same stream with trailer 05 -> err=1; then load_req -> cpu_rst_n=0, in_ready=1.
